mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch path and the load/store path of the 5-stage core, one outstanding transaction at a time. Load/store has priority; a streak counter guarantees fetch progress. A fetch flush input discards a stale fetch response after a branch redirect. Sits between `ifu`/`lsu` and the memory/bus model.

## Interface
Parameters:
- `CPU_WIDTH`, 64, address/data width.
- `MAX_LS_STREAK`, 4, consecutive LS grants allowed while IF is waiting; range 1..15.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_if_req`  in  1  fetch request; held until `o_if_gnt`.
- `i_if_addr`  in  CPU_WIDTH  fetch address.
- `i_if_flush`  in  1  cancel any accepted, not-yet-returned fetch.
- `o_if_gnt`  out  1  fetch request accepted this cycle.
- `o_if_rvalid`  out  1  fetch data valid, one cycle.
- `o_if_rdata`  out  CPU_WIDTH  fetch data.
- `i_ls_req`, `i_ls_wen`  in  1  LS request; 1 = store.
- `i_ls_addr`, `i_ls_wdata`  in  CPU_WIDTH  LS address, store data.
- `i_ls_wmask`  in  CPU_WIDTH/8  byte strobes.
- `o_ls_gnt`, `o_ls_rvalid`  out  1  LS accepted; LS completion (load data or store ack).
- `o_ls_rdata`  out  CPU_WIDTH  load data.
- `o_mem_req`, `o_mem_wen`  out  1  memory request, write flag.
- `o_mem_addr`, `o_mem_wdata`  out  CPU_WIDTH.
- `o_mem_wmask`  out  CPU_WIDTH/8.
- `i_mem_gnt`  in  1  memory accepted `o_mem_req`.
- `i_mem_rvalid`  in  1  response/completion valid.
- `i_mem_rdata`  in  CPU_WIDTH  response data.

## Operation
- States: IDLE, REQ (driving `o_mem_req`, waiting `i_mem_gnt`), WAIT (waiting `i_mem_rvalid`).
- IDLE: if any request, select owner, assert that owner's `gnt` combinationally, latch addr/wen/wdata/wmask/owner into registers, go REQ. Otherwise stay.
- Selection: LS wins, unless `i_if_req` && streak == MAX_LS_STREAK, then IF wins.
- Streak: on LS grant with `i_if_req`=1, +1; on LS grant with `i_if_req`=0 or any IF grant, 0.
- Fetch is always `wen`=0, `wmask`=0.
- REQ: `o_mem_*` driven from latched registers; on `i_mem_gnt` go WAIT.
- WAIT: on `i_mem_rvalid`, route `i_mem_rdata` to the owner's rdata with a one-cycle `rvalid`, go IDLE.
- Flush: `i_if_flush` in any cycle while owner=IF in REQ/WAIT sets `drop`. A dropped response is consumed (state returns to IDLE) with `o_if_rvalid`=0. `drop` clears on return to IDLE. Flush never cancels LS and never withdraws an already-issued `o_mem_req`.
- `i_mem_rvalid` outside WAIT is ignored. `i_mem_gnt` outside REQ is ignored.

## Timing
- Reset: state IDLE, streak 0, drop 0, latched regs 0; all outputs 0.
- Min latency: req+gnt at cycle 0, `o_mem_req` at 1; with `i_mem_gnt` at 1, WAIT at 2; with `i_mem_rvalid` at 2, owner `rvalid` at 2; IDLE at 3, next grant at 3.
- `o_if_rdata`/`o_ls_rdata` are combinational pass-through of `i_mem_rdata`, qualified by their rvalid.
- Grants are only issued in IDLE: never two grants in one cycle, never a grant while a transaction is outstanding.
- Simultaneous flush and rvalid on the IF response: the response is dropped.
- Reset during REQ/WAIT: immediate IDLE. A late `i_mem_rvalid` is ignored.

## Structure
- Shared package `arb_pkg`: `arb_state_e` {IDLE, REQ, WAIT}, `arb_owner_e` {OWN_IF, OWN_LS}.
- Width constants come from `config.sv` (`CPU_WIDTH`).
- One sub-module, `arb_prio_sel`: combinational selection plus the streak counter register. FSM and latches live in the top.

## Test plan
- Single LS load at 0x80000010; mem gnt at +1, rvalid at +2 with 0xDEADBEEF -> `o_ls_gnt` at 0, `o_ls_rvalid`=1 with 0xDEADBEEF at 2, no `o_if_rvalid`.
- IF and LS requests asserted together -> LS granted first; IF granted in the cycle after LS completion.
- IF held high with LS requesting continuously, MAX_LS_STREAK=4 -> exactly 4 LS grants, then 1 IF grant, then streak is 0.
- IF granted, `i_if_flush` pulsed in WAIT, then rvalid -> `o_if_rvalid` stays 0; FSM returns to IDLE; the next IF request completes normally.
- Store with wmask 0x0F and `i_mem_gnt` delayed 3 cycles -> `o_mem_req`/addr/wdata/wmask stable for all 4 REQ cycles; completion asserts `o_ls_rvalid`.
- `i_rst` asserted during WAIT, then a spurious rvalid -> all outputs 0, no rvalid forwarded, clean grant after reset release.

Source files
------------

// File: rtl/arb_pkg.sv
// Types shared by the memory port arbiter and its priority selector.
// State and owner encodings plus the streak counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_e;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/config.sv
// Core-wide width constants shared by the memory-side blocks.
// The arbiter takes its default data/address width from here.
package cfg_pkg;

    localparam int CPU_WIDTH = 64;

endpackage

// File: rtl/arb_prio_sel.sv
// Picks the next memory port owner: load/store first, but fetch
// wins once load/store has been served MAX_LS_STREAK times in a row.
module arb_prio_sel
    import arb_pkg::*;
#(
    parameter int MAX_LS_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ls_req,
    input  logic en,
    output logic if_sel,
    output logic ls_sel
);

    logic [STREAK_W-1:0] streak;
    logic                if_due;

    // Fetch is owed the port once the streak limit is reached.
    always_comb begin
        if_due = if_req && (streak == STREAK_W'(MAX_LS_STREAK));
        ls_sel = en && ls_req && !if_due;
        if_sel = en && if_req && !ls_sel;
    end

    // Count LS grants that made a waiting fetch stand aside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (ls_sel) begin
            streak <= if_req ? streak + 1'b1 : '0;
        end else if (if_sel) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and load/store,
// one outstanding transaction at a time, with fetch flush support.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int CPU_WIDTH     = cfg_pkg::CPU_WIDTH,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_if_req,
    input  logic [CPU_WIDTH-1:0]   i_if_addr,
    input  logic                   i_if_flush,
    output logic                   o_if_gnt,
    output logic                   o_if_rvalid,
    output logic [CPU_WIDTH-1:0]   o_if_rdata,
    input  logic                   i_ls_req,
    input  logic                   i_ls_wen,
    input  logic [CPU_WIDTH-1:0]   i_ls_addr,
    input  logic [CPU_WIDTH-1:0]   i_ls_wdata,
    input  logic [CPU_WIDTH/8-1:0] i_ls_wmask,
    output logic                   o_ls_gnt,
    output logic                   o_ls_rvalid,
    output logic [CPU_WIDTH-1:0]   o_ls_rdata,
    output logic                   o_mem_req,
    output logic                   o_mem_wen,
    output logic [CPU_WIDTH-1:0]   o_mem_addr,
    output logic [CPU_WIDTH-1:0]   o_mem_wdata,
    output logic [CPU_WIDTH/8-1:0] o_mem_wmask,
    input  logic                   i_mem_gnt,
    input  logic                   i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0]   i_mem_rdata
);

    localparam int MW = CPU_WIDTH / 8;

    arb_state_e           state;
    arb_owner_e           owner;
    logic                 drop;
    logic                 wen_q;
    logic [CPU_WIDTH-1:0] addr_q;
    logic [CPU_WIDTH-1:0] wdata_q;
    logic [MW-1:0]        wmask_q;

    logic                 sel_en;
    logic                 if_sel;
    logic                 ls_sel;
    logic                 rsp;
    logic                 own_if;

    assign sel_en = (state == IDLE) && !i_rst;
    assign own_if = (owner == OWN_IF);
    assign rsp    = (state == WAIT) && i_mem_rvalid;

    arb_prio_sel #(
        .MAX_LS_STREAK (MAX_LS_STREAK)
    ) u_sel (
        .clk    (i_clk),
        .rst    (i_rst),
        .if_req (i_if_req),
        .ls_req (i_ls_req),
        .en     (sel_en),
        .if_sel (if_sel),
        .ls_sel (ls_sel)
    );

    // Transaction FSM: latch the winner, issue, wait, then return.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            drop    <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ls_sel) begin
                        owner   <= OWN_LS;
                        wen_q   <= i_ls_wen;
                        addr_q  <= i_ls_addr;
                        wdata_q <= i_ls_wdata;
                        wmask_q <= i_ls_wmask;
                        state   <= REQ;
                    end else if (if_sel) begin
                        owner   <= OWN_IF;
                        wen_q   <= 1'b0;
                        addr_q  <= i_if_addr;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        state <= WAIT;
                    end
                    if (i_if_flush && own_if) begin
                        drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (i_if_flush && own_if) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Grants, memory request and response routing.
    always_comb begin
        o_if_gnt    = if_sel;
        o_ls_gnt    = ls_sel;
        o_mem_req   = (state == REQ);
        o_mem_wen   = o_mem_req ? wen_q : 1'b0;
        o_mem_addr  = o_mem_req ? addr_q : '0;
        o_mem_wdata = o_mem_req ? wdata_q : '0;
        o_mem_wmask = o_mem_req ? wmask_q : '0;
        o_if_rvalid = rsp && own_if && !drop && !i_if_flush;
        o_ls_rvalid = rsp && !own_if;
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    end

endmodule
